// File: rtl/c2_arb_pkg.sv
// Shared types and operand layout for the C2 cell arbiter.
// The operand byte maps one-to-one onto the shared cell's data and select pins.
package c2_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int OP_W   = 8;
  localparam int OP_D00 = 7;
  localparam int OP_D01 = 6;
  localparam int OP_D10 = 5;
  localparam int OP_D11 = 4;
  localparam int OP_A1  = 3;
  localparam int OP_B1  = 2;
  localparam int OP_A0  = 1;
  localparam int OP_B0  = 0;

endpackage

// File: rtl/rr_arbiter_next.sv
// Combinational round-robin pick: the first set request at or after the pointer,
// searched cyclically, returned as one-hot, index and an any-request flag.
module rr_arbiter_next #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  win_onehot,
  output logic [IDX_W-1:0] win_idx,
  output logic             win_any
);

  int win_j;

  // Scan offsets from far to near so the nearest requester at/after ptr wins last.
  always_comb begin
    win_j   = 0;
    win_any = 1'b0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      if (req[(int'(ptr) + off) % NREQ]) begin
        win_j   = (int'(ptr) + off) % NREQ;
        win_any = 1'b1;
      end else begin
        win_j   = win_j;
        win_any = win_any;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      win_onehot[i] = win_any && (i == win_j);
    end
    win_idx = IDX_W'(win_j);
  end

endmodule

// File: rtl/c2_cell_arbiter.sv
// Time-shares one external C2 mux cell between NREQ requesters: grant, drive the
// cell from registers, let it settle, capture its output and return it with the ID.
module c2_cell_arbiter
  import c2_arb_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int EVAL_CYCLES = 1,
  parameter int CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [OP_W*NREQ-1:0]     req_op,
  output logic [NREQ-1:0]          grant,
  output logic                     busy,
  output logic                     c2_d00,
  output logic                     c2_d01,
  output logic                     c2_d10,
  output logic                     c2_d11,
  output logic                     c2_a1,
  output logic                     c2_b1,
  output logic                     c2_a0,
  output logic                     c2_b0,
  input  logic                     c2_out,
  output logic                     resp_valid,
  output logic [$clog2(NREQ)-1:0]  resp_id,
  output logic                     resp_data,
  output logic [CNT_W-1:0]         op_count
);

  localparam int IDX_W  = $clog2(NREQ);
  localparam int CNT_EW = (EVAL_CYCLES > 1) ? $clog2(EVAL_CYCLES) : 1;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    win_q, win_d;
  logic [CNT_EW-1:0]   cnt_q, cnt_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic                busy_q, busy_d;
  logic [NREQ-1:0]     grant_q, grant_d;
  logic                rv_q, rv_d;
  logic [IDX_W-1:0]    rid_q, rid_d;
  logic                rdata_q, rdata_d;
  logic [CNT_W-1:0]    opcnt_q, opcnt_d;

  logic [NREQ-1:0]     arb_onehot_s;
  logic [IDX_W-1:0]    arb_idx_s;
  logic                arb_any_s;
  logic [OP_W-1:0]     op_sel_s;
  logic                eval_last_s;

  rr_arbiter_next #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req        (req),
    .ptr        (ptr_q),
    .win_onehot (arb_onehot_s),
    .win_idx    (arb_idx_s),
    .win_any    (arb_any_s)
  );

  // Operand of the current winner, picked by the one-hot grant.
  always_comb begin
    op_sel_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_onehot_s[i]) begin
        op_sel_s = req_op[i*OP_W +: OP_W];
      end else begin
        op_sel_s = op_sel_s;
      end
    end
  end

  assign eval_last_s = (cnt_q == CNT_EW'(EVAL_CYCLES - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = arb_any_s   ? ST_EVAL : ST_IDLE;
      ST_EVAL: state_d = eval_last_s ? ST_DONE : ST_EVAL;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values; outputs are all taken from registers.
  always_comb begin
    ptr_d   = ptr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    busy_d  = busy_q;
    grant_d = grant_q;
    rv_d    = rv_q;
    rid_d   = rid_q;
    rdata_d = rdata_q;
    opcnt_d = opcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_any_s) begin
          op_d   = op_sel_s;
          win_d  = arb_idx_s;
          busy_d = 1'b1;
          cnt_d  = '0;
        end else begin
          op_d   = op_q;
          busy_d = busy_q;
        end
      end
      ST_EVAL: begin
        cnt_d = cnt_q + CNT_EW'(1);
        if (eval_last_s) begin
          rdata_d = c2_out;
          rid_d   = win_q;
          rv_d    = 1'b1;
          grant_d = {{(NREQ-1){1'b0}}, 1'b1} << win_q;
          opcnt_d = opcnt_q + CNT_W'(1);
        end else begin
          rv_d    = rv_q;
          grant_d = grant_q;
        end
      end
      ST_DONE: begin
        rv_d    = 1'b0;
        grant_d = '0;
        busy_d  = 1'b0;
        ptr_d   = (win_q == IDX_W'(NREQ - 1)) ? '0 : win_q + IDX_W'(1);
      end
      default: begin
        rv_d    = 1'b0;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Datapath registers; a reset mid-operation drops the transaction silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      busy_q  <= 1'b0;
      grant_q <= '0;
      rv_q    <= 1'b0;
      rid_q   <= '0;
      rdata_q <= 1'b0;
      opcnt_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      busy_q  <= busy_d;
      grant_q <= grant_d;
      rv_q    <= rv_d;
      rid_q   <= rid_d;
      rdata_q <= rdata_d;
      opcnt_q <= opcnt_d;
    end
  end

  assign grant      = grant_q;
  assign busy       = busy_q;
  assign resp_valid = rv_q;
  assign resp_id    = rid_q;
  assign resp_data  = rdata_q;
  assign op_count   = opcnt_q;
  assign c2_d00     = op_q[OP_D00];
  assign c2_d01     = op_q[OP_D01];
  assign c2_d10     = op_q[OP_D10];
  assign c2_d11     = op_q[OP_D11];
  assign c2_a1      = op_q[OP_A1];
  assign c2_b1      = op_q[OP_B1];
  assign c2_a0      = op_q[OP_A0];
  assign c2_b0      = op_q[OP_B0];

endmodule

// File: tb/tb_c2_cell_arbiter.sv
// Directed bench for c2_cell_arbiter with a behavioural C2 cell looped back to c2_out.
module tb_c2_cell_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic [31:0] req_op = 32'h0;
  logic [3:0]  grant;
  logic        busy;
  logic        c2_d00, c2_d01, c2_d10, c2_d11, c2_a1, c2_b1, c2_a0, c2_b0;
  logic        c2_out;
  logic        resp_valid;
  logic [1:0]  resp_id;
  logic        resp_data;
  logic [15:0] op_count;
  logic [7:0]  drive;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  c2_cell_arbiter #(.NREQ(4), .EVAL_CYCLES(1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_op(req_op),
    .grant(grant), .busy(busy),
    .c2_d00(c2_d00), .c2_d01(c2_d01), .c2_d10(c2_d10), .c2_d11(c2_d11),
    .c2_a1(c2_a1), .c2_b1(c2_b1), .c2_a0(c2_a0), .c2_b0(c2_b0),
    .c2_out(c2_out), .resp_valid(resp_valid), .resp_id(resp_id),
    .resp_data(resp_data), .op_count(op_count)
  );

  // Shared C2 cell: 4:1 mux, sel = {a1|b1, a0&b0}.
  assign c2_out = (c2_a1 | c2_b1) ? ((c2_a0 & c2_b0) ? c2_d11 : c2_d10)
                                  : ((c2_a0 & c2_b0) ? c2_d01 : c2_d00);
  assign drive  = {c2_d00, c2_d01, c2_d10, c2_d11, c2_a1, c2_b1, c2_a0, c2_b0};

  function automatic logic gold(input logic [7:0] op);
    logic s1, s0;
    s1 = op[3] | op[2];
    s0 = op[1] & op[0];
    case ({s1, s0})
      2'b00:   return op[7];
      2'b01:   return op[6];
      2'b10:   return op[5];
      default: return op[4];
    endcase
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Raise one request at a negedge and wait (bounded) for its response.
  task automatic do_op(input int idx, input logic [7:0] op, output bit found,
                       output int lat, output logic [1:0] id, output logic data,
                       output logic [3:0] gnt);
    found = 1'b0; lat = 0; id = 2'd0; data = 1'b0; gnt = 4'd0;
    req_op[idx*8 +: 8] = op;
    req[idx] = 1'b1;
    for (int c = 1; c <= 20 && !found; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        found = 1'b1; lat = c; id = resp_id; data = resp_data; gnt = grant;
      end
    end
    req[idx] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 4'b0000;
    req_op = 32'h0;
    @(negedge clk);
    n_checks++;
    if ({grant, busy, drive, resp_valid, resp_id, resp_data, op_count} !== 33'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got grant=%b busy=%b drive=%b rv=%b id=%0d data=%b cnt=%0d, want all 0",
               grant, busy, drive, resp_valid, resp_id, resp_data, op_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    bit found; int lat; logic [1:0] id; logic data; logic [3:0] gnt;
    do_op(0, 8'b0010_1000, found, lat, id, data, gnt);
    n_checks++;
    if (!found || lat != 2) begin
      n_fail++;
      $display("FAIL single_latency: got found=%0d lat=%0d, want found=1 lat=2", found, lat);
    end
    n_checks++;
    if ({id, data, gnt} !== {2'd0, 1'b1, 4'b0001}) begin
      n_fail++;
      $display("FAIL single_resp: got id=%0d data=%b grant=%b, want id=0 data=1 grant=0001", id, data, gnt);
    end
    n_checks++;
    if ({busy, resp_valid, grant, op_count} !== {1'b0, 1'b0, 4'b0000, 16'd1}) begin
      n_fail++;
      $display("FAIL single_after: got busy=%b rv=%b grant=%b cnt=%0d, want 0 0 0000 1",
               busy, resp_valid, grant, op_count);
    end
    do_op(2, 8'b0001_0011, found, lat, id, data, gnt);
    n_checks++;
    if (!found || {id, data, gnt} !== {2'd2, 1'b0, 4'b0100}) begin
      n_fail++;
      $display("FAIL single_req2: got found=%0d id=%0d data=%b grant=%b, want 1 id=2 data=0 grant=0100",
               found, id, data, gnt);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] ops [4];
    int ids [5]; int tms [5]; logic dats [5]; logic [15:0] cnts [5]; logic [3:0] gnts [5];
    int n;
    apply_reset();
    ops[0] = 8'b1000_0000; ops[1] = 8'b0100_0011; ops[2] = 8'b0010_0100; ops[3] = 8'b0000_0110;
    for (int i = 0; i < 4; i++) req_op[i*8 +: 8] = ops[i];
    req = 4'b1111;
    n = 0;
    for (int c = 1; c <= 40 && n < 5; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        ids[n] = resp_id; dats[n] = resp_data; cnts[n] = op_count; gnts[n] = grant; tms[n] = c;
        n++;
      end
    end
    req = 4'b0000;
    @(negedge clk);
    n_checks++;
    if (n != 5) begin
      n_fail++;
      $display("FAIL rr_count: got %0d responses, want 5", n);
    end
    for (int k = 0; k < n; k++) begin
      n_checks++;
      if (ids[k] != k % 4 || dats[k] !== gold(ops[k % 4]) || cnts[k] !== 16'(k + 1)
          || gnts[k] !== (4'b0001 << (k % 4))) begin
        n_fail++;
        $display("FAIL rr_resp%0d: got id=%0d data=%b cnt=%0d grant=%b, want id=%0d data=%b cnt=%0d",
                 k, ids[k], dats[k], cnts[k], gnts[k], k % 4, gold(ops[k % 4]), k + 1);
      end
      if (k > 0) begin
        n_checks++;
        if (tms[k] - tms[k-1] != 3) begin
          n_fail++;
          $display("FAIL rr_throughput%0d: got spacing %0d, want 3", k, tms[k] - tms[k-1]);
        end
      end
    end
  endtask

  task automatic test_pointer_wrap();
    bit found; int lat; logic [1:0] id; logic data; logic [3:0] gnt;
    int ids [2]; int n;
    do_op(2, 8'b0000_0000, found, lat, id, data, gnt);
    n_checks++;
    if (!found || id !== 2'd2) begin
      n_fail++;
      $display("FAIL wrap_setup: got found=%0d id=%0d, want 1 id=2", found, id);
    end
    req_op[7:0] = 8'b1000_0000;
    req_op[31:24] = 8'b0001_1111;
    req = 4'b1001;
    n = 0;
    for (int c = 1; c <= 20 && n < 2; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        ids[n] = resp_id;
        req[resp_id] = 1'b0;
        n++;
      end
    end
    req = 4'b0000;
    @(negedge clk);
    n_checks++;
    if (n != 2 || ids[0] != 3 || ids[1] != 0) begin
      n_fail++;
      $display("FAIL wrap_order: got n=%0d ids=%0d,%0d, want 2 ids=3,0", n, ids[0], ids[1]);
    end
  endtask

  task automatic test_reset_mid_op();
    bit found; int lat; logic [1:0] id; logic data; logic [3:0] gnt;
    req_op[15:8] = 8'hFF;
    req[1] = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midop_busy: got busy=%b, want 1", busy);
    end
    rst_n = 1'b0;
    req = 4'b0000;
    #1;
    n_checks++;
    if ({grant, busy, drive, resp_valid, resp_id, resp_data, op_count} !== 33'd0) begin
      n_fail++;
      $display("FAIL midop_async: got busy=%b drive=%b rv=%b cnt=%0d, want all 0",
               busy, drive, resp_valid, op_count);
    end
    @(negedge clk);
    n_checks++;
    if ({resp_valid, grant} !== 5'd0) begin
      n_fail++;
      $display("FAIL midop_noresp: got rv=%b grant=%b, want 0 0000", resp_valid, grant);
    end
    rst_n = 1'b1;
    @(negedge clk);
    do_op(1, 8'b1000_0010, found, lat, id, data, gnt);
    n_checks++;
    if (!found || {id, data, gnt, op_count} !== {2'd1, 1'b1, 4'b0010, 16'd1}) begin
      n_fail++;
      $display("FAIL midop_after: got found=%0d id=%0d data=%b grant=%b cnt=%0d, want 1 id=1 data=1 grant=0010 cnt=1",
               found, id, data, gnt, op_count);
    end
  endtask

  task automatic test_all_operands();
    logic [7:0] op;
    for (int v = 0; v < 256; v++) begin
      op = 8'(v);
      req_op[15:8] = op;
      req[1] = 1'b1;
      @(negedge clk);
      req_op[15:8] = ~op;
      @(negedge clk);
      n_checks++;
      if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_data !== gold(op) || drive !== op) begin
        n_fail++;
        $display("FAIL operand_%02h: got rv=%b id=%0d data=%b drive=%b, want rv=1 id=1 data=%b drive=%b",
                 op, resp_valid, resp_id, resp_data, drive, gold(op), op);
      end
      req[1] = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_pointer_wrap();
    test_reset_mid_op();
    test_all_operands();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
